// File: rtl/uart_pkg.sv
// uart_pkg: shared baud arithmetic and state encodings for the UART blocks
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  function automatic logic [15:0] baud_cnt_max(input int unsigned clk_freq, input int unsigned bps);
    return 16'(clk_freq / bps);
  endfunction
  localparam logic [15:0] BAUD_CNT_MAX = baud_cnt_max(50_000_000, 9600);
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: three-stage synchronizer for the serial line with falling-edge detect
module uart_rx_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic rx,
  output logic rx_reg2,
  output logic fall
);
  logic rx_reg1, rx_reg3;
  // shift the line through three flops; reset to the idle-high level
  always_ff @(posedge sys_clk)
    if (!sys_rst_n) {rx_reg1, rx_reg2, rx_reg3} <= 3'b111;
    else {rx_reg1, rx_reg2, rx_reg3} <= {rx, rx_reg1, rx_reg2};
  assign fall = rx_reg3 & ~rx_reg2;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver sampling each bit at the middle of its baud period
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned UART_BPS = 'd9600,
  parameter int unsigned CLK_FREQ = 'd50_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       rx,
  output logic [7:0] po_data,
  output logic       po_flag,
  output logic       frame_err
);
  localparam logic [15:0] baud_max = baud_cnt_max(CLK_FREQ, UART_BPS);
  localparam logic [15:0] half_bit = baud_max >> 1;
  uart_state_t state, state_next;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic        rx_reg2, fall, sample, load, err;
  uart_rx_sync u_sync (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .rx       (rx),
    .rx_reg2  (rx_reg2),
    .fall     (fall)
  );
  assign sample = (state != IDLE) && (baud_cnt == half_bit);
  // next-state and stop-bit verdict; a low stop bit reports an error instead of loading
  always_comb begin
    state_next = state;
    load = 1'b0;
    err = 1'b0;
    case (state)
      IDLE:  state_next = fall ? START : IDLE;
      START: state_next = sample ? (rx_reg2 ? IDLE : DATA) : START;
      DATA:  state_next = (sample && bit_cnt == 3'd7) ? STOP : DATA;
      STOP: begin
        state_next = sample ? IDLE : STOP;
        load = sample & rx_reg2;
        err = sample & ~rx_reg2;
      end
    endcase
  end
  // state, baud/bit counters, byte assembly and registered output pulses
  always_ff @(posedge sys_clk)
    if (!sys_rst_n) begin
      state <= IDLE;
      baud_cnt <= '0;
      bit_cnt <= '0;
      shift <= '0;
      po_data <= '0;
      po_flag <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state <= state_next;
      baud_cnt <= (state == IDLE || baud_cnt == baud_max - 16'd1) ? '0 : baud_cnt + 16'd1;
      bit_cnt <= (state != DATA) ? 3'd0 : sample ? bit_cnt + 3'd1 : bit_cnt;
      if (state == DATA && sample) shift[bit_cnt] <= rx_reg2;
      po_data <= load ? shift : po_data;
      po_flag <= load;
      frame_err <= err;
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames against a fast-baud receiver plus a default-rate glitch check
module tb_uart_rx;
  localparam int M = 50_000_000 / 115200;
  localparam int H = M / 2;
  localparam int LAT = 9 * M + H + 3;
  logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1, rx_d = 1'b1;
  logic [7:0] po_data, po_data_d;
  logic po_flag, frame_err, po_flag_d, frame_err_d;
  logic prev_flag = 1'b0, prev_err = 1'b0;
  int checks = 0, errors = 0;
  int cyc = 0, t_fall = 0, flag_cyc = 0;
  int flag_cnt = 0, err_cnt = 0, overlap_cnt = 0, wide_cnt = 0, flag_cnt_d = 0, err_cnt_d = 0;
  logic [7:0] data_log [16];

  always #5 clk = ~clk;

  uart_rx #(.UART_BPS(115200), .CLK_FREQ(50_000_000)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .rx(rx),
    .po_data(po_data), .po_flag(po_flag), .frame_err(frame_err)
  );
  uart_rx dut_def (
    .sys_clk(clk), .sys_rst_n(rst_n), .rx(rx_d),
    .po_data(po_data_d), .po_flag(po_flag_d), .frame_err(frame_err_d)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // pulse monitor sampled on the falling edge
  always @(negedge clk) begin
    prev_flag <= po_flag;
    prev_err <= frame_err;
    if (po_flag) begin
      data_log[flag_cnt[3:0]] <= po_data;
      flag_cnt <= flag_cnt + 1;
      flag_cyc <= cyc;
    end
    if (frame_err) err_cnt <= err_cnt + 1;
    if (po_flag && frame_err) overlap_cnt <= overlap_cnt + 1;
    if ((po_flag && prev_flag) || (frame_err && prev_err)) wide_cnt <= wide_cnt + 1;
    if (po_flag_d) flag_cnt_d <= flag_cnt_d + 1;
    if (frame_err_d) err_cnt_d <= err_cnt_d + 1;
  end

  task automatic send_byte(input logic [7:0] d, input logic stop);
    t_fall = cyc;
    rx = 1'b0;
    repeat (M) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (M) @(negedge clk);
    end
    rx = stop;
    repeat (M) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (po_data !== 8'h00) begin errors++; $display("FAIL reset_po_data got %h want 00", po_data); end
    checks++; if (po_flag !== 1'b0) begin errors++; $display("FAIL reset_po_flag got %b want 0", po_flag); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (flag_cnt !== 0) begin errors++; $display("FAIL reset_idle_flags got %0d want 0", flag_cnt); end
  endtask

  task automatic test_single;
    int f0, e0, lat;
    f0 = flag_cnt; e0 = err_cnt;
    send_byte(8'h55, 1'b1);
    repeat (10) @(negedge clk);
    lat = flag_cyc - t_fall - 1;
    checks++; if (flag_cnt !== f0 + 1) begin errors++; $display("FAIL single_flag_count got %0d want %0d", flag_cnt - f0, 1); end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL single_err_count got %0d want 0", err_cnt - e0); end
    checks++; if (po_data !== 8'h55) begin errors++; $display("FAIL single_data got %h want 55", po_data); end
    checks++; if (lat < LAT - 1 || lat > LAT + 1) begin errors++; $display("FAIL single_latency got %0d want %0d+/-1", lat, LAT); end
  endtask

  task automatic test_back_to_back;
    int f0, e0;
    f0 = flag_cnt; e0 = err_cnt;
    send_byte(8'hA3, 1'b1);
    send_byte(8'h0F, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (flag_cnt !== f0 + 2) begin errors++; $display("FAIL b2b_flag_count got %0d want 2", flag_cnt - f0); end
    checks++; if (data_log[f0[3:0]] !== 8'hA3) begin errors++; $display("FAIL b2b_first got %h want a3", data_log[f0[3:0]]); end
    checks++; if (data_log[4'(f0 + 1)] !== 8'h0F) begin errors++; $display("FAIL b2b_second got %h want 0f", data_log[4'(f0 + 1)]); end
    checks++; if (err_cnt !== e0) begin errors++; $display("FAIL b2b_err_count got %0d want 0", err_cnt - e0); end
  endtask

  task automatic test_glitch;
    int f0, e0;
    f0 = flag_cnt; e0 = err_cnt;
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (2 * M) @(negedge clk);
    checks++; if (flag_cnt !== f0 || err_cnt !== e0) begin errors++; $display("FAIL glitch_fast got flag %0d err %0d want 0 0", flag_cnt - f0, err_cnt - e0); end
    rx_d = 1'b0;
    repeat (1000) @(negedge clk);
    rx_d = 1'b1;
    repeat (4000) @(negedge clk);
    checks++; if (flag_cnt_d !== 0) begin errors++; $display("FAIL glitch_default_flag got %0d want 0", flag_cnt_d); end
    checks++; if (err_cnt_d !== 0) begin errors++; $display("FAIL glitch_default_err got %0d want 0", err_cnt_d); end
  endtask

  task automatic test_override;
    int f0;
    f0 = flag_cnt;
    send_byte(8'h81, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (flag_cnt !== f0 + 1) begin errors++; $display("FAIL override_flag_count got %0d want 1", flag_cnt - f0); end
    checks++; if (po_data !== 8'h81) begin errors++; $display("FAIL override_data got %h want 81", po_data); end
  endtask

  task automatic test_frame_err;
    int f0, e0;
    f0 = flag_cnt; e0 = err_cnt;
    send_byte(8'hFF, 1'b0);
    repeat (10) @(negedge clk);
    checks++; if (err_cnt !== e0 + 1) begin errors++; $display("FAIL ferr_err_count got %0d want 1", err_cnt - e0); end
    checks++; if (flag_cnt !== f0) begin errors++; $display("FAIL ferr_flag_count got %0d want 0", flag_cnt - f0); end
    checks++; if (po_data !== 8'h81) begin errors++; $display("FAIL ferr_data_held got %h want 81", po_data); end
  endtask

  task automatic test_reset_midframe;
    int f0, e0;
    logic [7:0] d;
    f0 = flag_cnt; e0 = err_cnt;
    d = 8'h3C;
    rx = 1'b0;
    repeat (M) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (M) @(negedge clk);
    end
    rx = d[4];
    repeat (H) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (10 * M) @(negedge clk);
    checks++; if (flag_cnt !== f0 || err_cnt !== e0) begin errors++; $display("FAIL abort_pulses got flag %0d err %0d want 0 0", flag_cnt - f0, err_cnt - e0); end
    checks++; if (po_data !== 8'h00) begin errors++; $display("FAIL abort_data got %h want 00", po_data); end
    send_byte(8'hC3, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (flag_cnt !== f0 + 1) begin errors++; $display("FAIL abort_resume_flag got %0d want 1", flag_cnt - f0); end
    checks++; if (po_data !== 8'hC3) begin errors++; $display("FAIL abort_resume_data got %h want c3", po_data); end
  endtask

  task automatic test_pulse_shape;
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL flag_err_overlap got %0d want 0", overlap_cnt); end
    checks++; if (wide_cnt !== 0) begin errors++; $display("FAIL pulse_width got %0d wide pulses want 0", wide_cnt); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_override;
    test_frame_err;
    test_reset_midframe;
    test_pulse_shape;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
